haar_feature_calculator: RTL
============================

Name: haar_feature_calculator

Overview:
Responder side of the cascade's feature-calculation handshake. On calc_start it fetches a Haar feature descriptor (header plus up to 3 weighted rectangles) from the feature ROM. For each rectangle it reads 4 integral-image corners and accumulates weight × rect_sum. It returns the signed feature_value with a one-cycle calc_done pulse to the stage-evaluation FSM that issued the request.

Parameters:
DATA_WIDTH, 32, width of ROM words, integral-image words and feature_value; must be >= 32.
II_STRIDE, 321, integral-image row pitch in words (image width + 1).
II_ADDR_WIDTH, 17, integral-image address width.

Ports:
clk  input  1  clock
rst  input  1  reset
calc_start  input  1  request pulse; sampled only in IDLE
feature_index  input  12  feature number; sampled with calc_start
win_x  input  8  detection-window x offset; sampled with calc_start
win_y  input  8  detection-window y offset; sampled with calc_start
feature_value  output  DATA_WIDTH  signed result; valid from calc_done until next calc_done
calc_done  output  1  one-cycle completion pulse
busy  output  1  high from the accepted request until the calc_done cycle inclusive
feat_rom_addr  output  14  feature ROM address (registered)
feat_rom_data  input  DATA_WIDTH  feature ROM data; synchronous, 1-cycle read latency
ii_addr  output  II_ADDR_WIDTH  integral-image address (registered)
ii_data  input  DATA_WIDTH  integral-image data; synchronous, 1-cycle read latency

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values: state IDLE; feature_value 0, calc_done 0, busy 0, feat_rom_addr 0, ii_addr 0, accumulator 0.
- Reset mid-operation aborts the request. calc_done is not produced for the aborted request.
- ROM layout: feature base address = feature_index*4.
  - Word base+0 is the header; [1:0] = num_rects (0..3).
  - Words base+1..base+3 are rectangles: [5:0] x, [11:6] y, [17:12] w, [23:18] h, [31:24] signed 8-bit weight.
- Every read (ROM or integral image) takes 2 cycles: address registered, one wait cycle, data captured on the next edge.
- States and transitions:
  - IDLE: on calc_start, latch inputs, set feat_rom_addr=base, busy=1 -> HDR_WAIT.
  - HDR_WAIT -> HDR.
  - HDR: capture num_rects, clear accumulator, rect_i=0. If num_rects==0 -> DONE; else feat_rom_addr=base+1 -> RECT_WAIT.
  - RECT_WAIT -> RECT.
  - RECT: latch x,y,w,h,weight; compute 4 corner addresses; ii_addr=A -> C_WAIT.
  - C_WAIT -> C_CAP.
  - C_CAP: capture corner k. If k<3, ii_addr=next corner -> C_WAIT; else -> MAC.
  - MAC: acc += weight*(D - B - C + A); rect_i++. If rect_i+1<num_rects, feat_rom_addr=base+2+rect_i -> RECT_WAIT; else -> DONE.
  - DONE: feature_value=acc (wrap or saturate, see Optional Feature), calc_done=1 for one cycle, busy=0 -> IDLE.
- Corner order:
  - A=(wx+x, wy+y)
  - B=(wx+x+w, wy+y)
  - C=(wx+x, wy+y+h)
  - D=(wx+x+w, wy+y+h)
- Corner address = row*II_STRIDE + col, truncated modulo 2^II_ADDR_WIDTH. No range check is performed; the caller guarantees in-range windows.
- Arithmetic:
  - rect_sum is signed DATA_WIDTH with wrapping subtraction.
  - The product is DATA_WIDTH+8 bits; the accumulator is DATA_WIDTH+10 bits signed.
- Latency: calc_done is high in the cycle following edge 3+11*num_rects, counted from the edge that sampled calc_start (num_rects=0: 3; 2: 25; 3: 36).
- calc_start while busy is ignored; no queueing.
- calc_start in the calc_done cycle is ignored. The earliest re-accept is the cycle after calc_done.
- num_rects field value 0 returns feature_value=0 with the normal done pulse.

Optional Feature:
Macro HAAR_FEAT_SAT_EN.
- Defined: in DONE the accumulator saturates to the signed DATA_WIDTH range (max 0x7FFFFFFF, min 0x80000000 for 32 bits).
- Undefined: the low DATA_WIDTH bits are taken (two's-complement wrap).
- Latency is identical in both builds.

Test Plan:
- Integral image of all-ones pixels (II(c,r)=c*r, stride 321). Feature 5: rect (0,0,4,4,w=-1) and rect (0,0,2,4,w=+3). calc_start with win 0,0 -> feature_value=8, calc_done 25 cycles after start, one-cycle pulse.
- Same feature with win_x=10, win_y=20 -> feature_value=8. ii_addr sequence begins 20*321+10=6430, then 6434.
- Header num_rects=0 -> feature_value=0, calc_done 3 cycles after start, no ii_addr activity.
- 3-rect feature with weights +1,-2,+1 on equal 2×2 rects -> value 0, done at 36 cycles. Second calc_start pulses during busy are ignored (exactly one calc_done).
- Overflow: II corners give rect_sum=0x40000000, weight +127.
  - HAAR_FEAT_SAT_EN defined -> feature_value=0x7FFFFFFF.
  - Undefined -> 0xC0000000 (low 32 bits of 127*2^30).
- Assert rst at cycle 12 of a request -> all outputs 0 immediately, no calc_done. A new request after release completes with the correct value.

Source files
------------

// File: rtl/haar_feature_calculator.sv
// Haar feature evaluator: fetches a descriptor (header + up to 3 weighted rectangles) from the
// feature ROM and accumulates weight * rect_sum from the integral image. Macro HAAR_FEAT_SAT_EN saturates the result.
module haar_feature_calculator #(
  parameter int DATA_WIDTH    = 32,
  parameter int II_STRIDE     = 321,
  parameter int II_ADDR_WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     calc_start,
  input  logic [11:0]              feature_index,
  input  logic [7:0]               win_x,
  input  logic [7:0]               win_y,
  output logic [DATA_WIDTH-1:0]    feature_value,
  output logic                     calc_done,
  output logic                     busy,
  output logic [13:0]              feat_rom_addr,
  input  logic [DATA_WIDTH-1:0]    feat_rom_data,
  output logic [II_ADDR_WIDTH-1:0] ii_addr,
  input  logic [DATA_WIDTH-1:0]    ii_data
);

  localparam int PROD_W = DATA_WIDTH + 8;
  localparam int ACC_W  = DATA_WIDTH + 10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_HDR_WAIT  = 4'd1,
    S_HDR       = 4'd2,
    S_RECT_WAIT = 4'd3,
    S_RECT      = 4'd4,
    S_C_WAIT    = 4'd5,
    S_C_CAP     = 4'd6,
    S_MAC       = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t                  state_q, state_d;
  logic [13:0]             base_q, base_d;
  logic [7:0]              wx_q, wx_d, wy_q, wy_d;
  logic [1:0]              num_rects_q, num_rects_d;
  logic [1:0]              rect_i_q, rect_i_d;
  logic [7:0]              weight_q, weight_d;
  logic [9:0]              col0_q, col0_d, col1_q, col1_d;
  logic [9:0]              row0_q, row0_d, row1_q, row1_d;
  logic [1:0]              corner_k_q, corner_k_d;
  logic [DATA_WIDTH-1:0]   corner_q [4];
  logic [DATA_WIDTH-1:0]   corner_d [4];
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   feature_value_q, feature_value_d;
  logic                    calc_done_q, calc_done_d;
  logic                    busy_q, busy_d;
  logic [13:0]             feat_rom_addr_q, feat_rom_addr_d;
  logic [II_ADDR_WIDTH-1:0] ii_addr_q, ii_addr_d;

  logic [5:0]              rx_s, ry_s, rw_s, rh_s;
  logic [9:0]              col0_s, col1_s, row0_s, row1_s;
  logic [1:0]              next_k_s;
  logic [9:0]              next_col_s, next_row_s;
  logic [DATA_WIDTH-1:0]   rect_sum_s;
  logic signed [PROD_W-1:0] prod_s;
  logic                    mac_more_s;
  logic [DATA_WIDTH-1:0]   result_s;
  logic                    unused_rom_s;

  function automatic logic [II_ADDR_WIDTH-1:0] corner_addr(input logic [9:0] col,
                                                           input logic [9:0] row);
    logic [31:0] full;
    full = 32'(row) * 32'(II_STRIDE) + 32'(col);
    return full[II_ADDR_WIDTH-1:0];
  endfunction

`ifdef HAAR_FEAT_SAT_EN
  function automatic logic [DATA_WIDTH-1:0] clamp_acc(input logic [ACC_W-1:0] acc);
    logic [DATA_WIDTH-1:0] res;
    if (acc[ACC_W-1:DATA_WIDTH-1] == {(ACC_W-DATA_WIDTH+1){acc[ACC_W-1]}}) begin
      res = acc[DATA_WIDTH-1:0];
    end else if (acc[ACC_W-1]) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return res;
  endfunction
  assign result_s = clamp_acc(acc_q);
`else
  assign result_s = acc_q[DATA_WIDTH-1:0];
`endif

  // Rectangle word fields and its corner coordinates relative to the latched window.
  assign rx_s   = feat_rom_data[5:0];
  assign ry_s   = feat_rom_data[11:6];
  assign rw_s   = feat_rom_data[17:12];
  assign rh_s   = feat_rom_data[23:18];
  assign col0_s = {2'b00, wx_q} + {4'b0000, rx_s};
  assign col1_s = col0_s + {4'b0000, rw_s};
  assign row0_s = {2'b00, wy_q} + {4'b0000, ry_s};
  assign row1_s = row0_s + {4'b0000, rh_s};

  // Corner index bit 0 selects +w, bit 1 selects +h (A, B, C, D).
  assign next_k_s   = corner_k_q + 2'd1;
  assign next_col_s = next_k_s[0] ? col1_q : col0_q;
  assign next_row_s = next_k_s[1] ? row1_q : row0_q;

  assign rect_sum_s = corner_q[3] - corner_q[1] - corner_q[2] + corner_q[0];
  assign prod_s     = $signed({{DATA_WIDTH{weight_q[7]}}, weight_q})
                    * $signed({{8{rect_sum_s[DATA_WIDTH-1]}}, rect_sum_s});
  assign mac_more_s = ({1'b0, rect_i_q} + 3'd1) < {1'b0, num_rects_q};
  assign unused_rom_s = ^feat_rom_data;

  // Next-state and datapath update for the fetch / corner-read / accumulate sequence.
  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    wx_d            = wx_q;
    wy_d            = wy_q;
    num_rects_d     = num_rects_q;
    rect_i_d        = rect_i_q;
    weight_d        = weight_q;
    col0_d          = col0_q;
    col1_d          = col1_q;
    row0_d          = row0_q;
    row1_d          = row1_q;
    corner_k_d      = corner_k_q;
    corner_d        = corner_q;
    acc_d           = acc_q;
    feature_value_d = feature_value_q;
    calc_done_d     = 1'b0;
    busy_d          = busy_q;
    feat_rom_addr_d = feat_rom_addr_q;
    ii_addr_d       = ii_addr_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // A request in the calc_done cycle is dropped; busy is still high there.
        if (calc_start && !calc_done_q) begin
          base_d          = {feature_index, 2'b00};
          wx_d            = win_x;
          wy_d            = win_y;
          feat_rom_addr_d = {feature_index, 2'b00};
          busy_d          = 1'b1;
          state_d         = S_HDR_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR_WAIT: state_d = S_HDR;
      S_HDR: begin
        num_rects_d = feat_rom_data[1:0];
        acc_d       = {ACC_W{1'b0}};
        rect_i_d    = 2'd0;
        if (feat_rom_data[1:0] == 2'd0) begin
          state_d = S_DONE;
        end else begin
          feat_rom_addr_d = base_q + 14'd1;
          state_d         = S_RECT_WAIT;
        end
      end
      S_RECT_WAIT: state_d = S_RECT;
      S_RECT: begin
        weight_d   = feat_rom_data[31:24];
        col0_d     = col0_s;
        col1_d     = col1_s;
        row0_d     = row0_s;
        row1_d     = row1_s;
        corner_k_d = 2'd0;
        ii_addr_d  = corner_addr(col0_s, row0_s);
        state_d    = S_C_WAIT;
      end
      S_C_WAIT: state_d = S_C_CAP;
      S_C_CAP: begin
        corner_d[corner_k_q] = ii_data;
        if (corner_k_q != 2'd3) begin
          corner_k_d = next_k_s;
          ii_addr_d  = corner_addr(next_col_s, next_row_s);
          state_d    = S_C_WAIT;
        end else begin
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d    = acc_q + {{2{prod_s[PROD_W-1]}}, prod_s};
        rect_i_d = rect_i_q + 2'd1;
        if (mac_more_s) begin
          feat_rom_addr_d = base_q + 14'd2 + {12'd0, rect_i_q};
          state_d         = S_RECT_WAIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        feature_value_d = result_s;
        calc_done_d     = 1'b1;
        state_d         = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; rst aborts any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      base_q          <= 14'd0;
      wx_q            <= 8'd0;
      wy_q            <= 8'd0;
      num_rects_q     <= 2'd0;
      rect_i_q        <= 2'd0;
      weight_q        <= 8'd0;
      col0_q          <= 10'd0;
      col1_q          <= 10'd0;
      row0_q          <= 10'd0;
      row1_q          <= 10'd0;
      corner_k_q      <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        corner_q[i] <= {DATA_WIDTH{1'b0}};
      end
      acc_q           <= {ACC_W{1'b0}};
      feature_value_q <= {DATA_WIDTH{1'b0}};
      calc_done_q     <= 1'b0;
      busy_q          <= 1'b0;
      feat_rom_addr_q <= 14'd0;
      ii_addr_q       <= {II_ADDR_WIDTH{1'b0}};
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      wx_q            <= wx_d;
      wy_q            <= wy_d;
      num_rects_q     <= num_rects_d;
      rect_i_q        <= rect_i_d;
      weight_q        <= weight_d;
      col0_q          <= col0_d;
      col1_q          <= col1_d;
      row0_q          <= row0_d;
      row1_q          <= row1_d;
      corner_k_q      <= corner_k_d;
      corner_q        <= corner_d;
      acc_q           <= acc_d;
      feature_value_q <= feature_value_d;
      calc_done_q     <= calc_done_d;
      busy_q          <= busy_d;
      feat_rom_addr_q <= feat_rom_addr_d;
      ii_addr_q       <= ii_addr_d;
    end
  end

  assign feature_value = feature_value_q;
  assign calc_done     = calc_done_q;
  assign busy          = busy_q;
  assign feat_rom_addr = feat_rom_addr_q;
  assign ii_addr       = ii_addr_q;

endmodule
